cordic_iter_ctrl: RTL and testbench
===================================

// Module: cordic_iter_ctrl
// PURPOSE
//  Iterative CORDIC rotation-mode engine: one shared shift/add/sub datapath reused over N_ITER cycles.
//  Takes (X,Y,Z) over a valid/ready handshake and returns the rotated (X,Y) plus the residual angle.
//  Contains the sequencing FSM, the iteration counter, the arctan ROM and the variable shifters.
//  Area-saving alternative to the unrolled per-stage pipeline; sits between the angle source and the sin/cos consumers.
// PARAMETERS
//  N_ITER  14  iterations per operation, range 1..16; iteration i uses shift i, i = 0..N_ITER-1
//  CNT_W   4   iteration counter width; must satisfy 2^CNT_W >= N_ITER
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  in_valid   in   1   x_in/y_in/z_in valid
//  in_ready   out  1   engine can accept an operand set
//  x_in       in   18  signed Q2.15
//  y_in       in   18  signed Q2.15
//  z_in       in   18  signed Q2.15 radians, usable range |z| <= 1.743 rad
//  abort      in   1   synchronous cancel of the current operation
//  out_valid  out  1   x_out/y_out/z_out valid
//  out_ready  in   1   consumer takes the result
//  x_out      out  18  rotated X, signed Q2.15
//  y_out      out  18  rotated Y, signed Q2.15
//  z_out      out  18  residual angle, signed Q2.15
//  busy       out  1   high in ITER or DONE
//  iter       out  CNT_W  current iteration index; 0 when not in ITER
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; X/Y/Z registers, x_out/y_out/z_out, iter and out_valid all cleared to 0;
//    busy=0; in_ready=1 from the first cycle after release.
//  States and transitions:
//    IDLE: in_ready=1. in_valid & ~abort -> load X,Y,Z; iter=0; go to ITER.
//    ITER: one micro-rotation per cycle. After iteration N_ITER-1 -> DONE.
//    DONE: out_valid=1; outputs held stable while out_ready=0. out_ready=1 -> IDLE.
//  Micro-rotation i, with d = ~Z[17] (Z >= 0). All three updates use pre-update values:
//    d=1: X -= Y>>>i; Y += X>>>i; Z -= atan_i
//    d=0: X += Y>>>i; Y -= X>>>i; Z += atan_i
//  >>> is an arithmetic (sign-filling) shift. Add/sub is two's complement mod 2^18: no saturation, wrap permitted.
//  atan_i = round(atan(2^-i)*2^15) from an internal ROM: 25736, 15193, 8027, 4075, 2045, 1024, 512, 256, 128,
//    64, 32, 16, 8, 4, 2, 1 for i = 0..15.
//  No gain compensation: the caller pre-scales X by K = 0.607253 (19898 in Q2.15).
//  Latency: handshake accepted in cycle t -> out_valid high in cycle t+N_ITER+1.
//    Minimum spacing between accepts is N_ITER+2 cycles.
//  in_ready is combinational from state only (== state==IDLE), never from in_valid.
//  abort: in ITER or DONE -> IDLE next cycle; out_valid drops without any output transfer.
//    In IDLE, abort blocks the accept that cycle. abort and out_ready both high in DONE -> IDLE, counted as aborted.
//  Output registers are written only on the ITER->DONE transition; x_out/y_out/z_out keep their last values in IDLE.
//  Reset asserted mid-operation: immediate clear; no out_valid is produced for the interrupted operation.
// TESTING
//  1. x=19898,y=0,z=0 -> after 15 cycles out_valid; x_out=32768+-14, y_out=0+-14, |z_out|<=2.
//  2. x=19898,y=0,z=51472 (pi/2) -> x_out=0+-14, y_out=32768+-14. z=-51472 -> y_out=-32768+-14.
//  3. Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. Then pulse out_ready
//     -> IDLE the next cycle and back-to-back accept at spacing 16.
//  4. abort at iter=5 -> IDLE next cycle, out_valid never asserted. A new op (z=25736) completes with
//     x_out=y_out=23170+-14.
//  5. rst_n low at iter=7, with in_valid held high -> outputs 0 asynchronously; accept 1 cycle after release.
//  6. Sweep N_ITER=1 and 16; random |z|<=1.74 vs a real-valued model -> error <= N_ITER LSB; latency exactly N_ITER+1.

Source files
------------

// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl
//   Iterative CORDIC engine in rotation mode. A single shift/add/sub datapath
//   is reused for N_ITER cycles per operation. It rotates (X,Y) by the angle Z
//   and returns the rotated vector and the residual angle. No gain
//   compensation is applied: the caller pre-scales X by K (19898 in Q2.15).
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; x_in/y_in/z_in are signed Q2.15
//   abort               synchronous cancel; blocks an accept while IDLE
//   out_valid/out_ready result handshake; x_out/y_out/z_out are signed Q2.15
//   busy                high while iterating or holding a result
//   iter                current iteration index, 0 outside ITER
//   dbg_state           raw FSM state for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on the state, never on in_valid.
// out_valid stays high, with stable data, until out_ready (or abort) is seen.

module cordic_iter_ctrl #(
  parameter int N_ITER = 14,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      x_in,
  input  logic [17:0]      y_in,
  input  logic [17:0]      z_in,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [17:0]      x_out,
  output logic [17:0]      y_out,
  output logic [17:0]      z_out,
  output logic             busy,
  output logic [CNT_W-1:0] iter,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ITER - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [17:0] x_q, y_q, z_q;
  logic signed [17:0] x_d, y_d, z_d;
  logic [17:0]        x_out_q, y_out_q, z_out_q;
  logic               load_out;

  logic signed [17:0] x_sh, y_sh, atan_val;
  logic signed [17:0] x_rot, y_rot, z_rot;

  // round(atan(2^-i) * 2^15) for i = 0..15
  function automatic logic [17:0] atan_rom(input int idx);
    case (idx)
      0:       return 18'd25736;
      1:       return 18'd15193;
      2:       return 18'd8027;
      3:       return 18'd4075;
      4:       return 18'd2045;
      5:       return 18'd1024;
      6:       return 18'd512;
      7:       return 18'd256;
      8:       return 18'd128;
      9:       return 18'd64;
      10:      return 18'd32;
      11:      return 18'd16;
      12:      return 18'd8;
      13:      return 18'd4;
      14:      return 18'd2;
      15:      return 18'd1;
      default: return 18'd0;
    endcase
  endfunction

  // Shared micro-rotation datapath; all updates use the pre-update X/Y/Z.
  always_comb begin
    x_sh     = x_q >>> cnt_q;
    y_sh     = y_q >>> cnt_q;
    atan_val = $signed(atan_rom(int'(cnt_q)));
    if (!z_q[17]) begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - atan_val;
    end else begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + atan_val;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    load_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && !abort) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = z_in;
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          x_d = x_rot;
          y_d = y_rot;
          z_d = z_rot;
          if (cnt_q == LAST) begin
            cnt_d    = '0;
            load_out = 1'b1;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        // abort wins over out_ready: the result is dropped, not transferred
        if (abort || out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      // result registers change only when the last iteration completes
      if (load_out) begin
        x_out_q <= x_rot;
        y_out_q <= y_rot;
        z_out_q <= z_rot;
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_ITER) || (state_q == S_DONE);
  assign iter      = (state_q == S_ITER) ? cnt_q : '0;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign z_out     = z_out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
module tb_cordic_iter_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus for all three instances
  logic        in_valid = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [17:0] x_in = '0, y_in = '0, z_in = '0;

  // N_ITER = 14 instance
  logic        in_ready, out_valid, busy;
  logic [17:0] x_out, y_out, z_out;
  logic [3:0]  iter;
  logic [1:0]  dbg_state;
  // N_ITER = 1 instance
  logic        in_ready_n1, out_valid_n1, busy_n1;
  logic [17:0] x_out_n1, y_out_n1, z_out_n1;
  logic [3:0]  iter_n1;
  logic [1:0]  dbg_state_n1;
  // N_ITER = 16 instance
  logic        in_ready_n16, out_valid_n16, busy_n16;
  logic [17:0] x_out_n16, y_out_n16, z_out_n16;
  logic [3:0]  iter_n16;
  logic [1:0]  dbg_state_n16;

  cordic_iter_ctrl #(.N_ITER(14), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .busy(busy), .iter(iter), .dbg_state(dbg_state)
  );

  cordic_iter_ctrl #(.N_ITER(1), .CNT_W(4)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n1),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .abort(abort),
    .out_valid(out_valid_n1), .out_ready(out_ready),
    .x_out(x_out_n1), .y_out(y_out_n1), .z_out(z_out_n1),
    .busy(busy_n1), .iter(iter_n1), .dbg_state(dbg_state_n1)
  );

  cordic_iter_ctrl #(.N_ITER(16), .CNT_W(4)) dut_n16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n16),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .abort(abort),
    .out_valid(out_valid_n16), .out_ready(out_ready),
    .x_out(x_out_n16), .y_out(y_out_n16), .z_out(z_out_n16),
    .busy(busy_n16), .iter(iter_n16), .dbg_state(dbg_state_n16)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int atan_tab[16] = '{25736, 15193, 8027, 4075, 2045, 1024, 512, 256,
                       128, 64, 32, 16, 8, 4, 2, 1};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int s18(input logic [17:0] v);
    return int'($signed(v));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input real exp, input real tol);
    n_tests++;
    assert (((real'(obs) - exp) <= tol) && ((exp - real'(obs)) <= tol)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0.2f +- %0.1f", tag, obs, exp, tol);
    end
  endtask

  // Reference: the directions follow the sign of the integer residual angle;
  // the net rotation is the sum of the true atan(2^-i) angles, scaled by the
  // accumulated CORDIC gain of n micro-rotations.
  task automatic model(input int n, input int x, input int y, input int z,
                       output real xe, output real ye, output int ze);
    int  zr;
    real th, g, t;
    zr = z;
    th = 0.0;
    g  = 1.0;
    for (int i = 0; i < n; i++) begin
      t = 1.0 / real'(1 << i);
      if (zr >= 0) begin
        zr -= atan_tab[i];
        th += $atan(t);
      end else begin
        zr += atan_tab[i];
        th -= $atan(t);
      end
      g = g * $sqrt(1.0 + t * t);
    end
    xe = g * (real'(x) * $cos(th) - real'(y) * $sin(th));
    ye = g * (real'(y) * $cos(th) + real'(x) * $sin(th));
    ze = zr;
  endtask

  // drive one operand set for one cycle; returns one cycle after the accept edge
  task automatic send(input int x, input int y, input int z);
    x_in = 18'(x);
    y_in = 18'(y);
    z_in = 18'(z);
    in_valid = 1'b1;
    chk("send_in_ready", int'(in_ready), 1);
    tick;
    in_valid = 1'b0;
  endtask

  // lat = cycles from the accept cycle to the first out_valid cycle
  task automatic wait_valid(input int budget, output int lat);
    lat = 1;
    while (!out_valid && lat < budget) begin
      tick;
      lat++;
    end
    chk("out_valid_timeout", int'(out_valid), 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int  lat, seen, acc_n;
    int  acc_cyc[2];
    int  xr, yr, zr, ze;
    int  lat1, lat14, lat16;
    real xe, ye;

    // reset
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_iter", int'(iter), 0);
    chk("rst_x_out", s18(x_out), 0);
    chk("rst_y_out", s18(y_out), 0);
    chk("rst_z_out", s18(z_out), 0);

    // 1: zero angle
    out_ready = 1'b1;
    send(19898, 0, 0);
    chk("t1_busy", int'(busy), 1);
    chk("t1_iter0", int'(iter), 0);
    tick;
    chk("t1_iter1", int'(iter), 1);
    wait_valid(40, lat);
    lat = lat + 1;
    chk("t1_latency", lat, 15);
    chk_near("t1_x", s18(x_out), 32768.0, 14.0);
    chk_near("t1_y", s18(y_out), 0.0, 14.0);
    chk_near("t1_z", s18(z_out), 0.0, 2.0);
    tick;
    chk("t1_back_idle", int'(in_ready), 1);
    chk_near("t1_x_held", s18(x_out), 32768.0, 14.0);

    // 2: +/- pi/2
    send(19898, 0, 51472);
    wait_valid(40, lat);
    chk_near("t2_x_pos", s18(x_out), 0.0, 14.0);
    chk_near("t2_y_pos", s18(y_out), 32768.0, 14.0);
    tick;
    send(19898, 0, -51472);
    wait_valid(40, lat);
    chk_near("t2_x_neg", s18(x_out), 0.0, 14.0);
    chk_near("t2_y_neg", s18(y_out), -32768.0, 14.0);
    tick;

    // 3: result held under back-pressure, then back-to-back accepts
    out_ready = 1'b0;
    send(19898, 0, 25736);
    wait_valid(40, lat);
    for (int k = 0; k < 10; k++) begin
      chk("t3_hold_valid", int'(out_valid), 1);
      chk("t3_hold_ready", int'(in_ready), 0);
      chk_near("t3_hold_x", s18(x_out), 23170.0, 14.0);
      tick;
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("t3_pulse_idle", int'(in_ready), 1);
    chk("t3_pulse_valid", int'(out_valid), 0);
    chk_near("t3_idle_x_kept", s18(x_out), 23170.0, 14.0);

    out_ready = 1'b1;
    x_in = 18'(19898);
    y_in = '0;
    z_in = '0;
    in_valid = 1'b1;
    acc_n = 0;
    for (int k = 0; k < 40 && acc_n < 2; k++) begin
      if (in_ready) begin
        acc_cyc[acc_n] = cyc;
        acc_n++;
      end
      tick;
    end
    in_valid = 1'b0;
    chk("t3_b2b_count", acc_n, 2);
    chk("t3_b2b_spacing", acc_cyc[1] - acc_cyc[0], 16);
    wait_valid(40, lat);
    tick;

    // abort while holding a result; abort in IDLE blocks the accept
    out_ready = 1'b0;
    send(19898, 0, 1000);
    wait_valid(40, lat);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_done_valid", int'(out_valid), 0);
    chk("abort_done_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    abort = 1'b1;
    tick;
    in_valid = 1'b0;
    abort = 1'b0;
    chk("abort_idle_busy", int'(busy), 0);

    // 4: abort at iteration 5
    out_ready = 1'b1;
    send(19898, 0, 12345);
    for (int k = 0; k < 20 && iter != 4'd5; k++) tick;
    chk("t4_iter5", int'(iter), 5);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t4_idle", int'(in_ready), 1);
    chk("t4_busy", int'(busy), 0);
    chk("t4_iter", int'(iter), 0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      seen += int'(out_valid);
      tick;
    end
    chk("t4_no_valid", seen, 0);
    send(19898, 0, 25736);
    wait_valid(40, lat);
    chk_near("t4_x", s18(x_out), 23170.0, 14.0);
    chk_near("t4_y", s18(y_out), 23170.0, 14.0);
    tick;

    // 5: reset mid-operation with in_valid held high
    x_in = 18'(19898);
    y_in = '0;
    z_in = 18'(25736);
    in_valid = 1'b1;
    tick;
    for (int k = 0; k < 20 && iter != 4'd7; k++) tick;
    chk("t5_iter7", int'(iter), 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", int'(out_valid), 0);
    chk("t5_async_busy", int'(busy), 0);
    chk("t5_async_iter", int'(iter), 0);
    chk("t5_async_x", s18(x_out), 0);
    chk("t5_async_y", s18(y_out), 0);
    tick;
    rst_n = 1'b1;
    chk("t5_release_ready", int'(in_ready), 1);
    tick;
    in_valid = 1'b0;
    chk("t5_accept_busy", int'(busy), 1);
    chk("t5_accept_iter", int'(iter), 0);
    wait_valid(40, lat);
    chk_near("t5_x", s18(x_out), 23170.0, 14.0);
    repeat (20) tick;

    // 6: random angles on N_ITER = 1, 14 and 16 against the real-valued model
    out_ready = 1'b1;
    for (int r = 0; r < 12; r++) begin
      xr = int'($urandom_range(24000, 0)) - 12000;
      yr = int'($urandom_range(24000, 0)) - 12000;
      zr = int'($urandom_range(114000, 0)) - 57000;
      chk("t6_all_ready", int'({in_ready_n1, in_ready, in_ready_n16}), 7);
      x_in = 18'(xr);
      y_in = 18'(yr);
      z_in = 18'(zr);
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      lat1 = 0;
      lat14 = 0;
      lat16 = 0;
      for (int e = 1; e <= 20; e++) begin
        if (out_valid_n1 && lat1 == 0) lat1 = e;
        if (out_valid && lat14 == 0) lat14 = e;
        if (out_valid_n16 && lat16 == 0) lat16 = e;
        tick;
      end
      chk("t6_lat_n1", lat1, 2);
      chk("t6_lat_n14", lat14, 15);
      chk("t6_lat_n16", lat16, 17);

      model(1, xr, yr, zr, xe, ye, ze);
      chk_near("t6_x_n1", s18(x_out_n1), xe, 1.0);
      chk_near("t6_y_n1", s18(y_out_n1), ye, 1.0);
      chk("t6_z_n1", s18(z_out_n1), ze);

      model(14, xr, yr, zr, xe, ye, ze);
      chk_near("t6_x_n14", s18(x_out), xe, 14.0);
      chk_near("t6_y_n14", s18(y_out), ye, 14.0);
      chk("t6_z_n14", s18(z_out), ze);

      model(16, xr, yr, zr, xe, ye, ze);
      chk_near("t6_x_n16", s18(x_out_n16), xe, 16.0);
      chk_near("t6_y_n16", s18(y_out_n16), ye, 16.0);
      chk("t6_z_n16", s18(z_out_n16), ze);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
